// File: rtl/sym_pack_fifo.sv
// Bit FIFO that buffers a serial stream and issues 1-4 bit symbols over a valid/ready
// handshake, with occupancy status, sticky overflow/underflow flags and per-symbol mode select.
module sym_pack_fifo #(
    parameter int DEPTH     = 16,
    parameter int MAX_BPS   = 4,
    parameter int AFULL_LVL = 12,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         SELMod,
    input  logic               wEN,
    input  logic               dIn,
    output logic               bFull,
    output logic               bAfull,
    output logic               bEmpty,
    output logic [AW:0]        count,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic [MAX_BPS-1:0] sym_data,
    output logic               ovf,
    output logic               udf,
    input  logic               clr_err
);

    logic               r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [AW:0]        r_count;
    logic               r_sym_valid;
    logic [MAX_BPS-1:0] r_sym_data;
    logic               r_ovf;
    logic               r_udf;

    logic [2:0]         w_bps;
    logic [AW:0]        w_bps_ext;
    logic               w_full;
    logic               w_wr;
    logic               w_ld;
    logic [MAX_BPS-1:0] w_win;
    logic [MAX_BPS-1:0] w_sym;
    logic [2:0]         w_shift;
    logic [AW:0]        w_count_next;

    assign w_bps     = {1'b0, SELMod} + 3'd1;
    assign w_bps_ext = (AW+1)'(w_bps);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_wr      = wEN && !w_full;
    assign w_ld      = (!r_sym_valid || sym_ready) && (r_count >= w_bps_ext);
    assign w_shift   = 3'(MAX_BPS) - w_bps;

    // Gather the next MAX_BPS stored bits, oldest in the MSB; the shift trims to BPS.
    always_comb begin
        w_win = '0;
        for (int k = 0; k < MAX_BPS; k++) begin
            w_win[MAX_BPS-1-k] = r_mem[r_rptr[AW-1:0] + AW'(k)];
        end
        w_sym = w_win >> w_shift;
    end

    // Occupancy after this edge; a load only consumes bits already stored before the edge.
    always_comb begin
        if (w_ld) begin
            w_count_next = r_count + (AW+1)'(w_wr) - w_bps_ext;
        end else begin
            w_count_next = r_count + (AW+1)'(w_wr);
        end
    end

    // Bit storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= dIn;
        end
    end

    // Pointers, occupancy and the symbol output register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_sym_valid <= 1'b0;
            r_sym_data  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_ld) begin
                r_rptr      <= r_rptr + w_bps_ext;
                r_sym_data  <= w_sym;
                r_sym_valid <= 1'b1;
            end else if (sym_ready) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags; a set event in the same cycle overrides clr_err.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wEN && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (sym_ready && !r_sym_valid) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign bFull     = w_full;
    assign bAfull    = (r_count >= (AW+1)'(AFULL_LVL));
    assign bEmpty    = (r_count == '0);
    assign count     = r_count;
    assign sym_valid = r_sym_valid;
    assign sym_data  = r_sym_data;
    assign ovf       = r_ovf;
    assign udf       = r_udf;

endmodule

// File: tb/tb_sym_pack_fifo.sv
// Scoreboard bench for sym_pack_fifo: a queue-based reference model predicts symbols and status;
// a separate monitor pops expected symbols on every accepted handshake.
module tb_sym_pack_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] SELMod = 2'd0;
    logic       wEN = 1'b0;
    logic       dIn = 1'b0;
    logic       bFull, bAfull, bEmpty;
    logic [4:0] count;
    logic       sym_valid;
    logic       sym_ready = 1'b0;
    logic [3:0] sym_data;
    logic       ovf, udf;
    logic       clr_err = 1'b0;

    sym_pack_fifo #(.DEPTH(DEPTH), .MAX_BPS(4), .AFULL_LVL(AFULL)) dut (
        .CLK(CLK), .RESET(RESET), .SELMod(SELMod), .wEN(wEN), .dIn(dIn),
        .bFull(bFull), .bAfull(bAfull), .bEmpty(bEmpty), .count(count),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .ovf(ovf), .udf(udf), .clr_err(clr_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit q_bits[$];
    int exp_q[$];
    bit m_valid = 1'b0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;
    bit m_known = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_state();
        if (m_known) begin
            check("count", int'(count), q_bits.size());
            check("bEmpty", int'(bEmpty), int'(q_bits.size() == 0));
            check("bFull", int'(bFull), int'(q_bits.size() == DEPTH));
            check("bAfull", int'(bAfull), int'(q_bits.size() >= AFULL));
            check("sym_valid", int'(sym_valid), int'(m_valid));
            check("ovf", int'(ovf), int'(m_ovf));
            check("udf", int'(udf), int'(m_udf));
        end
    endfunction

    // advance the model across one clock edge using the inputs applied for that edge
    function automatic void model_edge(input bit wen, input bit din, input int bps,
                                       input bit rdy, input bit clr, input bit rstn);
        bit full;
        bit set_o;
        bit set_u;
        int sym;
        if (!rstn) begin
            q_bits.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_known = 1'b1;
        end else begin
            full = (q_bits.size() == DEPTH);
            set_o = wen && full;
            set_u = rdy && !m_valid;
            if ((!m_valid || rdy) && q_bits.size() >= bps) begin
                sym = 0;
                for (int i = 0; i < bps; i++) sym = sym * 2 + int'(q_bits.pop_front());
                exp_q.push_back(sym);
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (wen && !full) q_bits.push_back(din);
            m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_udf = set_u ? 1'b1 : (clr ? 1'b0 : m_udf);
        end
    endfunction

    task automatic step(input bit wen, input bit din, input logic [1:0] sel,
                        input bit rdy, input bit clr, input bit rstn);
        chk_state();
        RESET = rstn; wEN = wen; dIn = din; SELMod = sel; sym_ready = rdy; clr_err = clr;
        model_edge(wen, din, int'(sel) + 1, rdy, clr, rstn);
        @(posedge CLK);
        #1;
    endtask

    // monitor: every accepted handshake consumes the oldest predicted symbol
    always @(negedge CLK) begin
        if (RESET === 1'b1 && sym_valid === 1'b1 && sym_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_symbol", int'(sym_data), -1);
            end else begin
                check("sym_data", int'(sym_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        bit t1_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit t3_bits[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] rsel;

        // 1: BPS=2 stream with ready held high -> 2,3,0,2
        step(0, 0, 2'b01, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, t1_bits[i], 2'b01, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 1, 0, 1);
        check("t1_bEmpty", int'(bEmpty), 1);
        check("t1_drained", exp_q.size(), 0);

        // 2: fill with BPS=4 and ready low, then overflow and clear
        step(0, 0, 2'b11, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, i[0], 2'b11, 0, 0, 1);
        check("t2_count_full", int'(count), 16);
        check("t2_bFull", int'(bFull), 1);
        step(1, 1, 2'b11, 0, 0, 1);
        check("t2_ovf_set", int'(ovf), 1);
        step(0, 0, 2'b11, 0, 1, 1);
        check("t2_ovf_clr", int'(ovf), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 2'b11, 1, 0, 1);

        // 3: BPS=3 gives 6 then 5; then 6 followed by a switch to BPS=1
        step(0, 0, 2'b10, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, t3_bits[i], 2'b10, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b10, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, t3_bits[i], 2'b10, 1, 0, 1);
        step(0, 0, 2'b10, 1, 0, 1);
        for (int i = 3; i < 6; i++) step(1, t3_bits[i], 2'b00, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 2'b00, 1, 0, 1);
        check("t3_drained", exp_q.size(), 0);

        // 4: write and BPS=2 load in the same cycle from count=4, then wrap the pointers
        step(0, 0, 2'b01, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, i[1], 2'b01, 0, 0, 1);
        check("t4_count4", int'(count), 4);
        step(1, 1, 2'b01, 1, 0, 1);
        check("t4_count3", int'(count), 3);
        for (int i = 0; i < 60; i++) step(1, 1'($urandom), 2'b01, 1, 0, 1);

        // 5: underflow on empty, then reset mid-stream
        for (int i = 0; i < 6; i++) step(0, 0, 2'b00, 1, 0, 1);
        step(0, 0, 2'b00, 1, 0, 1);
        check("t5_udf", int'(udf), 1);
        check("t5_count_empty", int'(count), 0);
        for (int i = 0; i < 5; i++) step(1, 1'b1, 2'b11, 0, 0, 1);
        step(0, 0, 2'b11, 0, 0, 0);
        check("t5_rst_count", int'(count), 0);
        check("t5_rst_data", int'(sym_data), 0);
        check("t5_rst_valid", int'(sym_valid), 0);
        check("t5_rst_bEmpty", int'(bEmpty), 1);

        // randomized traffic against the model
        rsel = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rsel = 2'($urandom);
            step($urandom_range(0, 9) < 7, 1'($urandom), rsel, 1'($urandom),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 499) != 0);
        end
        for (int i = 0; i < 12; i++) step(0, 0, rsel, 1, 0, 1);
        chk_state();
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
